// File: rtl/pwm_demod_pkg.sv
// Shared types and constants for the PWM demodulator.
// Matches the framing used by the PWM DAC output stage.
package pwm_demod_pkg;

    localparam int unsigned DEFAULT_OUTPUT_WIDTH  = 12;
    localparam int unsigned DEFAULT_COUNTER_WIDTH = 10;
    localparam int unsigned DEFAULT_OFFSET        = 512;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
    localparam int unsigned DEFAULT_LOCK_FRAMES   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Frame length in clocks for a given counter width.
    function automatic int unsigned frame_len(input int unsigned cw);
        return 32'd1 << cw;
    endfunction

endpackage

// File: rtl/pwm_demod_sync_edge.sv
// Synchronizer chain for the asynchronous PWM pin followed by a registered
// edge detector; level, rise and fall are mutually time-aligned.
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    // Metastability chain; pwm_in enters at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    // Edge-detect register: the delayed level and its edges change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= sync_q[SYNC_STAGES-1];
            rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pwm_demod.sv
// Recovers the signed sample encoded in a frame-periodic PWM waveform and
// reports per-frame valid, lock and frame-error status.
module pwm_demod
    import pwm_demod_pkg::*;
#(
    parameter int unsigned OUTPUT_WIDTH  = DEFAULT_OUTPUT_WIDTH,
    parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int unsigned OFFSET        = DEFAULT_OFFSET,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int unsigned LOCK_FRAMES   = DEFAULT_LOCK_FRAMES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pwm_in,
    output logic [OUTPUT_WIDTH-1:0] data_out,
    output logic                    data_valid,
    output logic                    locked,
    output logic                    frame_err
);

    localparam int unsigned CNT_W     = COUNTER_WIDTH + 1;
    localparam int unsigned FRAME_LEN = frame_len(COUNTER_WIDTH);
    localparam int unsigned GOOD_W    = $clog2(LOCK_FRAMES + 1);

    logic level;
    logic rise;
    logic fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    state_t                  state_q,  state_d;
    logic [CNT_W-1:0]        period_q, period_d;
    logic [CNT_W-1:0]        high_q,   high_d;
    logic [GOOD_W-1:0]       good_q,   good_d;
    logic [OUTPUT_WIDTH-1:0] data_q,   data_d;
    logic                    valid_q,  valid_d;
    logic                    locked_q, locked_d;
    logic                    err_q,    err_d;

    logic [CNT_W-1:0]         period_inc_c;
    logic [CNT_W-1:0]         high_inc_c;
    logic [COUNTER_WIDTH-1:0] code_c;
    logic [OUTPUT_WIDTH-1:0]  sample_c;
    logic                     restart_c;
    logic                     emit_c;

    // Both counters saturate; high only advances on synchronized-high cycles.
    assign period_inc_c = (period_q == '1) ? period_q : period_q + CNT_W'(1);
    assign high_inc_c   = (level && (high_q != '1)) ? high_q + CNT_W'(1) : high_q;

    // Undo the transmitter offset modulo the frame length, then sign-extend.
    assign code_c   = COUNTER_WIDTH'(high_q) - COUNTER_WIDTH'(1) - COUNTER_WIDTH'(OFFSET);
    assign sample_c = OUTPUT_WIDTH'($signed(code_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            high_q   <= '0;
            good_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            high_q   <= high_d;
            good_q   <= good_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    // Frame tracking: boundaries come from rises or a synthesized stuck-high edge.
    always_comb begin
        state_d   = state_q;
        period_d  = (state_q == ST_IDLE) ? period_q : period_inc_c;
        high_d    = (state_q == ST_IDLE) ? high_q   : high_inc_c;
        good_d    = good_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        err_d     = 1'b0;
        restart_c = 1'b0;
        emit_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    restart_c = 1'b1;
                    state_d   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (high_q == CNT_W'(FRAME_LEN)) begin
                    emit_c    = 1'b1;
                    restart_c = 1'b1;
                    if (fall) begin
                        state_d = ST_LOW;
                    end
                end else if (fall) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    restart_c = 1'b1;
                    state_d   = ST_HIGH;
                    if (period_q == CNT_W'(FRAME_LEN)) begin
                        emit_c = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        good_d   = '0;
                        locked_d = 1'b0;
                    end
                end else if (period_q >= CNT_W'(FRAME_LEN + 1)) begin
                    err_d    = 1'b1;
                    good_d   = '0;
                    locked_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The boundary cycle itself is the first cycle of the new frame.
        if (restart_c) begin
            period_d = CNT_W'(1);
            high_d   = CNT_W'(level);
        end

        if (emit_c) begin
            valid_d = 1'b1;
            data_d  = sample_c;
            if (good_q < GOOD_W'(LOCK_FRAMES)) begin
                good_d = good_q + GOOD_W'(1);
            end
            if ((32'(good_q) + 32'd1) >= LOCK_FRAMES) begin
                locked_d = 1'b1;
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign locked     = locked_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod: drives PWM frames and checks recovered
// samples, strobe spacing, lock and frame-error behaviour.
module tb_pwm_demod;

    localparam int unsigned OW = 12;
    localparam int unsigned CW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [OW-1:0] data_out;
    logic          data_valid;
    logic          locked;
    logic          frame_err;

    pwm_demod #(
        .OUTPUT_WIDTH (OW),
        .COUNTER_WIDTH(CW),
        .OFFSET       (512),
        .SYNC_STAGES  (2),
        .LOCK_FRAMES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .locked    (locked),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_err = 0;
    int n_both = 0;
    int last_start = 0;
    logic [OW-1:0] v_data[$];
    logic          v_lock[$];
    int            v_cyc[$];
    logic          e_lock[$];

    always @(posedge clk) cyc = cyc + 1;

    // Event log of strobes, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) begin
                v_data.push_back(data_out);
                v_lock.push_back(locked);
                v_cyc.push_back(cyc);
            end
            if (frame_err) begin
                n_err = n_err + 1;
                e_lock.push_back(locked);
            end
            if (data_valid && frame_err) n_both = n_both + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        v_data.delete();
        v_lock.delete();
        v_cyc.delete();
        e_lock.delete();
        n_err = 0;
        n_both = 0;
    endtask

    task automatic send_frame(input int high, input int period);
        for (int i = 0; i < period; i++) begin
            @(negedge clk);
            pwm_in = (i < high);
            if (i == 0 && high > 0) last_start = cyc;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout got=%0d exp=finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [OW-1:0] exp_ab[10];
        logic          lck_ab[10];
        logic          lck_c[4];
        int            s22;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Code 0, extremes, stuck-high run, return to mid-scale
        exp_ab = '{12'h000, 12'h000, 12'h000, 12'h000, 12'hE00,
                   12'h1FE, 12'h1FF, 12'h1FF, 12'h1FF, 12'h000};
        lck_ab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        clear_log();
        for (int f = 0; f < 4; f++) send_frame(513, 1024);
        send_frame(1, 1024);
        send_frame(1023, 1024);
        for (int f = 0; f < 3; f++) send_frame(1024, 1024);
        send_frame(513, 1024);
        send_frame(513, 1024);
        check("ab_count", 32'(v_data.size()), 32'd10);
        check("ab_err", 32'(n_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i < v_data.size()) begin
                check($sformatf("ab_data%0d", i), 32'(v_data[i]), 32'(exp_ab[i]));
                check($sformatf("ab_lock%0d", i), 32'(v_lock[i]), 32'(lck_ab[i]));
                if (i > 0) check($sformatf("ab_gap%0d", i), 32'(v_cyc[i] - v_cyc[i-1]), 32'd1024);
            end
        end

        // One short frame, then recovery
        lck_c = '{1'b1, 1'b0, 1'b1, 1'b1};
        clear_log();
        send_frame(513, 1000);
        for (int f = 0; f < 4; f++) send_frame(513, 1024);
        check("c_err", 32'(n_err), 32'd1);
        check("c_both", 32'(n_both), 32'd0);
        check("c_count", 32'(v_data.size()), 32'd4);
        if (e_lock.size() > 0) check("c_err_lock", 32'(e_lock[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < v_data.size()) begin
                check($sformatf("c_data%0d", i), 32'(v_data[i]), 32'h0);
                check($sformatf("c_lock%0d", i), 32'(v_lock[i]), 32'(lck_c[i]));
            end
        end

        // Loss of signal: pin held low past the frame length
        clear_log();
        send_frame(0, 1100);
        check("d_err", 32'(n_err), 32'd1);
        check("d_locked", 32'(locked), 32'd0);
        if (e_lock.size() > 0) check("d_err_lock", 32'(e_lock[0]), 32'd0);
        send_frame(1, 1024);
        check("d_idle_nosample", 32'(v_data.size()), 32'd0);
        send_frame(257, 1024);
        send_frame(1023, 1024);
        check("d_count", 32'(v_data.size()), 32'd2);
        if (v_data.size() == 2) begin
            check("d_data0", 32'(v_data[0]), 32'hE00);
            check("d_lock0", 32'(v_lock[0]), 32'd0);
            check("d_data1", 32'(v_data[1]), 32'hF00);
            check("d_lock1", 32'(v_lock[1]), 32'd1);
        end

        // Asynchronous reset during the high phase
        clear_log();
        fork
            send_frame(513, 1024);
            begin
                repeat (100) @(negedge clk);
                check("e_pre_count", 32'(v_data.size()), 32'd1);
                check("e_pre_data", 32'(data_out), 32'h1FE);
                check("e_pre_locked", 32'(locked), 32'd1);
                #($urandom_range(1, 9));
                rst_n = 1'b0;
                #1;
                check("e_rst_data", 32'(data_out), 32'h0);
                check("e_rst_valid", 32'(data_valid), 32'h0);
                check("e_rst_locked", 32'(locked), 32'h0);
                check("e_rst_err", 32'(frame_err), 32'h0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                clear_log();
            end
        join
        send_frame(769, 1024);
        send_frame(513, 1024);
        s22 = last_start;
        send_frame(513, 1024);
        check("e_count", 32'(v_data.size()), 32'd2);
        check("e_both", 32'(n_both), 32'd0);
        if (v_data.size() == 2) begin
            check("e_data0", 32'(v_data[0]), 32'h100);
            check("e_latency", 32'(v_cyc[0] - s22), 32'd4);
            check("e_data1", 32'(v_data[1]), 32'h000);
            check("e_gap", 32'(v_cyc[1] - v_cyc[0]), 32'd1024);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
